morse_msg_player: RTL
=====================

# morse_msg_player

Buffered, parametrised Morse message transmitter: the next-generation replacement for the single-character keypad-to-buzzer path. Accepts a stream of ASCII characters over a valid/ready interface and queues them in an internal FIFO. Plays the queued characters back to back with standard Morse timing: dot 1 unit, dash 3, intra-character gap 1, inter-character gap 3, word gap 7. Drives a key envelope and a gated square-wave tone suitable for the piezo buzzer.

## Interface
- DEPTH, 8: FIFO entries; power of 2, ≥2
- UNIT_CYCLES, 200000: clk cycles per Morse unit; 200 ms at 1 MHz; ≥2
- TONE_DIV, 500: tone half-period in clk cycles; 1 kHz at 1 MHz; ≥1
- clk  input  1  system clock, single clock domain
- rst  input  1  asynchronous, active-low reset
- in_data  input  8  ASCII character
- in_valid  input  1  character offered
- in_ready  output  1  FIFO can accept; 1 when level < DEPTH
- flush  input  1  synchronous abort: clears FIFO and playback
- key_out  output  1  Morse envelope; high during a dot or dash
- buzzer_out  output  1  tone; 0 whenever key_out=0
- busy  output  1  FSM not IDLE, or FIFO non-empty
- fifo_level  output  $clog2(DEPTH+1)  queued character count
- overflow  output  1  one-cycle pulse when in_valid=1 and in_ready=0
- bad_char  output  1  one-cycle pulse when an unsupported character is popped

## Operation
- Push: in_valid & in_ready writes in_data at the clock edge. in_ready is derived from the registered level only, so a pop in the same cycle does not admit a push when full.
- Encoder (internal):
  - A–Z, and a–z folded to upper case, map to a pattern of 1–4 symbols (1=dash), first symbol sent first.
  - Space (0x20) is a word-gap token.
  - Every other character is unsupported.
- FSM states: IDLE, LOAD, MARK, SGAP, CGAP, WGAP.
- IDLE: if the FIFO is non-empty → LOAD.
- LOAD: pops one entry.
  - Letter → MARK on symbol 0.
  - Space → WGAP.
  - Unsupported → pulse bad_char, then IDLE if the FIFO is empty, else LOAD. No time is emitted.
- MARK: key_out=1 for 1 unit (dot) or 3 units (dash). Then → SGAP if more symbols remain, else → CGAP.
- SGAP: 1 unit with key low, then → MARK on the next symbol.
- CGAP: 3 units with key low, then → LOAD if the FIFO is non-empty, else IDLE.
- WGAP: 4 units with key low; together with the preceding CGAP this gives 7 units. Then → LOAD or IDLE as for CGAP. Consecutive spaces add 4 units each.
- Tone: phase register is set to 1 on the MARK entry cycle and toggles every TONE_DIV cycles while in MARK. It is forced to 0 outside MARK. buzzer_out = phase.
- flush: FIFO level goes to 0, FSM goes to IDLE, and key_out and buzzer_out are 0 on the next cycle. flush wins over a simultaneous push, and that character is dropped with no overflow pulse.

## Timing
- Reset values: key_out, buzzer_out, busy, overflow, bad_char = 0; fifo_level = 0; in_ready = 1; FSM = IDLE.
- Reset asserted mid-character: all outputs return to their reset values immediately, without waiting for a clock edge.
- Latency from idle with an empty FIFO: push accepted at edge t; LOAD in cycle t+1; key_out rises in cycle t+2.
- Unit timer: counts 0..UNIT_CYCLES−1 and restarts on every state entry. State durations are exact multiples of UNIT_CYCLES.
- Pop and push in the same cycle leave the level unchanged.
- overflow and bad_char are registered, one cycle wide.

## Configuration
- MORSE_DIGITS_EN defined: digits 0–9 are encoded as their 5-symbol codes; symbol counter is 3 bits.
- MORSE_DIGITS_EN undefined: digits are unsupported and pulse bad_char.

## Test plan
Parameters for all scenarios: DEPTH=4, UNIT_CYCLES=4, TONE_DIV=2.
- Push "E" → key_out high 4 cycles, then low 12 cycles; busy falls after CGAP; buzzer_out toggles every 2 cycles while key is high.
- Push "A" → key high 4 cycles, low 4 cycles, high 12 cycles, low 12 cycles.
- Push "E E" → low interval between the two marks is 28 cycles (CGAP 12 + WGAP 16).
- Six back-to-back pushes from idle → five accepted, sixth rejected; overflow pulses once; fifo_level peaks at 4.
- Push "5":
  - with MORSE_DIGITS_EN: five 4-cycle marks.
  - without MORSE_DIGITS_EN: one bad_char pulse, key_out stays 0.
- flush mid-dash of "T" with two letters queued → key_out 0 next cycle, fifo_level 0, busy 0.
- Reset asserted mid-dash → key_out 0 immediately, fifo_level 0.

Source files
------------

// File: rtl/morse_msg_player.sv
// morse_msg_player: FIFO-buffered ASCII-to-Morse keyer with key envelope and gated tone.
// Define MORSE_DIGITS_EN to encode digits 0-9; otherwise digits are reported as bad_char.

module morse_msg_player #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned UNIT_CYCLES = 200000,
  parameter int unsigned TONE_DIV    = 500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       key_out,
  output logic                       buzzer_out,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  output logic                       bad_char
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);
  localparam int unsigned TickW = $clog2(UNIT_CYCLES);
  localparam int unsigned ToneW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
`ifdef MORSE_DIGITS_EN
  localparam int unsigned SymW  = 3;
  localparam int unsigned PatW  = 5;
`else
  localparam int unsigned SymW  = 2;
  localparam int unsigned PatW  = 4;
`endif
  localparam logic [TickW-1:0] TickLast = TickW'(UNIT_CYCLES - 1);
  localparam logic [ToneW-1:0] ToneLast = ToneW'(TONE_DIV - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StMark, StSgap, StCgap, StWgap} state_e;

  state_e              r_state, w_state_nxt;
  logic [7:0]          r_mem [DEPTH];
  logic [PtrW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LvlW-1:0]     r_level;
  logic [PatW-1:0]     r_pat;
  logic [SymW-1:0]     r_len_m1, r_sym_idx;
  logic [TickW-1:0]    r_tick;
  logic [2:0]          r_units;
  logic [ToneW-1:0]    r_tone_cnt;
  logic                r_phase, r_overflow, r_bad_char;

  logic                w_push, w_pop, w_load, w_restart, w_done, w_more;
  logic [7:0]          w_head, w_char;
  logic                w_is_letter, w_is_digit, w_is_sym, w_is_space;
  logic [SymW+PatW-1:0] w_code;
  logic [SymW-1:0]     w_sym_pos;
  logic                w_cur_sym;
  logic [2:0]          w_units_m1;

  assign in_ready   = (r_level < LvlW'(DEPTH));
  assign w_push     = in_valid & in_ready & ~flush;
  assign w_pop      = w_load & ~flush;
  assign key_out    = (r_state == StMark);
  assign buzzer_out = r_phase;
  assign busy       = (r_state != StIdle) || (r_level != '0);
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign bad_char   = r_bad_char;

  // Encoder: pattern is MSB-first over len bits, 1 = dash.
  function automatic logic [SymW+PatW-1:0] code(input int unsigned len, input logic [4:0] bits);
    return {SymW'(len - 1), PatW'(bits)};
  endfunction

  assign w_head      = r_mem[r_rd_ptr];
  assign w_char      = (w_head >= "a" && w_head <= "z") ? w_head - 8'h20 : w_head;
  assign w_is_letter = (w_char >= "A") && (w_char <= "Z");
`ifdef MORSE_DIGITS_EN
  assign w_is_digit  = (w_char >= "0") && (w_char <= "9");
`else
  assign w_is_digit  = 1'b0;
`endif
  assign w_is_sym    = w_is_letter | w_is_digit;
  assign w_is_space  = (w_char == 8'h20);

  always_comb begin
    w_code = '0;
    case (w_char)
      "A": w_code = code(2, 5'b01);    "B": w_code = code(4, 5'b1000);
      "C": w_code = code(4, 5'b1010);  "D": w_code = code(3, 5'b100);
      "E": w_code = code(1, 5'b0);     "F": w_code = code(4, 5'b0010);
      "G": w_code = code(3, 5'b110);   "H": w_code = code(4, 5'b0000);
      "I": w_code = code(2, 5'b00);    "J": w_code = code(4, 5'b0111);
      "K": w_code = code(3, 5'b101);   "L": w_code = code(4, 5'b0100);
      "M": w_code = code(2, 5'b11);    "N": w_code = code(2, 5'b10);
      "O": w_code = code(3, 5'b111);   "P": w_code = code(4, 5'b0110);
      "Q": w_code = code(4, 5'b1101);  "R": w_code = code(3, 5'b010);
      "S": w_code = code(3, 5'b000);   "T": w_code = code(1, 5'b1);
      "U": w_code = code(3, 5'b001);   "V": w_code = code(4, 5'b0001);
      "W": w_code = code(3, 5'b011);   "X": w_code = code(4, 5'b1001);
      "Y": w_code = code(4, 5'b1011);  "Z": w_code = code(4, 5'b1100);
`ifdef MORSE_DIGITS_EN
      "0": w_code = code(5, 5'b11111); "1": w_code = code(5, 5'b01111);
      "2": w_code = code(5, 5'b00111); "3": w_code = code(5, 5'b00011);
      "4": w_code = code(5, 5'b00001); "5": w_code = code(5, 5'b00000);
      "6": w_code = code(5, 5'b10000); "7": w_code = code(5, 5'b11000);
      "8": w_code = code(5, 5'b11100); "9": w_code = code(5, 5'b11110);
`endif
      default: w_code = '0;
    endcase
  end

  assign w_sym_pos = r_len_m1 - r_sym_idx;
  assign w_cur_sym = r_pat[w_sym_pos];

  always_comb begin
    w_units_m1 = 3'd0;
    case (r_state)
      StMark:  w_units_m1 = w_cur_sym ? 3'd2 : 3'd0;
      StCgap:  w_units_m1 = 3'd2;
      StWgap:  w_units_m1 = 3'd3;
      default: w_units_m1 = 3'd0;
    endcase
  end

  assign w_done = (r_tick == TickLast) && (r_units == w_units_m1);
  // Entries left after this pop (pop is only taken with a non-empty FIFO).
  assign w_more = (r_level != LvlW'(1)) || w_push;

  // Gap states pop the next entry on their last cycle so gaps stay exact unit multiples.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      StIdle: if (r_level != '0) w_state_nxt = StLoad;
      StLoad: w_load = 1'b1;
      StMark: if (w_done) w_state_nxt = (r_sym_idx == r_len_m1) ? StCgap : StSgap;
      StSgap: if (w_done) w_state_nxt = StMark;
      StCgap, StWgap: begin
        if (w_done) begin
          if (r_level != '0) w_load = 1'b1;
          else               w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_load) begin
      if (w_is_sym)        w_state_nxt = StMark;
      else if (w_is_space) w_state_nxt = StWgap;
      else                 w_state_nxt = w_more ? StLoad : StIdle;
    end
    if (flush) w_state_nxt = StIdle;
  end

  assign w_restart = (w_state_nxt != r_state) || w_load;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_level <= r_level + LvlW'(w_push) - LvlW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_pat      <= '0;
      r_len_m1   <= '0;
      r_sym_idx  <= '0;
      r_overflow <= 1'b0;
      r_bad_char <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_overflow <= in_valid & ~in_ready & ~flush;
      r_bad_char <= w_pop & ~w_is_sym & ~w_is_space;
      if (w_pop) begin
        r_pat     <= w_code[PatW-1:0];
        r_len_m1  <= w_code[SymW+PatW-1:PatW];
        r_sym_idx <= '0;
      end else if (r_state == StMark && w_done && r_sym_idx != r_len_m1) begin
        r_sym_idx <= r_sym_idx + SymW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick  <= '0;
      r_units <= '0;
    end else if (w_restart) begin
      r_tick  <= '0;
      r_units <= '0;
    end else if (r_tick == TickLast) begin
      r_tick  <= '0;
      r_units <= r_units + 3'd1;
    end else begin
      r_tick  <= r_tick + TickW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase    <= 1'b0;
      r_tone_cnt <= '0;
    end else if (w_state_nxt == StMark && r_state != StMark) begin
      r_phase    <= 1'b1;
      r_tone_cnt <= '0;
    end else if (w_state_nxt == StMark) begin
      if (r_tone_cnt == ToneLast) begin
        r_phase    <= ~r_phase;
        r_tone_cnt <= '0;
      end else begin
        r_tone_cnt <= r_tone_cnt + ToneW'(1);
      end
    end else begin
      r_phase    <= 1'b0;
      r_tone_cnt <= '0;
    end
  end

endmodule
